// File: rtl/mtm_alu_packer.sv
// Output-side frame builder: captures one ALU result or error report, runs a
// bit-serial CRC-3 over the data message and hands a 55-bit frame to the serializer.
module mtm_alu_packer #(
  parameter int HOLD_DATA = 60,
  parameter int HOLD_ERR  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] c,
  input  logic [3:0]  flags,
  input  logic [2:0]  err_flags,
  output logic [54:0] aluin,
  output logic        dataready
);

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CRC  = 2'd1,
    EMIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t           state;
  logic [31:0]      c_q;
  logic [3:0]       flags_q;
  logic [2:0]       crc_q;
  logic [5:0]       idx;
  logic [CNT_W-1:0] hold_cnt;
  logic             is_err;

  logic [36:0] msg;
  logic        msg_bit;
  logic        fb;
  logic [2:0]  crc_nxt;

  function automatic logic [10:0] packet(input logic is_ctl, input logic [7:0] payload);
    return {1'b0, is_ctl, payload, 1'b1};
  endfunction

  // Parity bit that makes the 8-bit error payload even.
  function automatic logic even_parity7(input logic [6:0] bits);
    return ^bits;
  endfunction

  function automatic logic [54:0] data_frame(input logic [31:0] cv, input logic [3:0] fv,
                                             input logic [2:0] crc);
    return {packet(1'b0, cv[31:24]), packet(1'b0, cv[23:16]),
            packet(1'b0, cv[15:8]),  packet(1'b0, cv[7:0]),
            packet(1'b1, {1'b0, fv, crc})};
  endfunction

  function automatic logic [54:0] err_frame(input logic [2:0] ev);
    logic [6:0] head;
    head = {1'b1, ev, ev};
    return {44'd0, packet(1'b1, {head, even_parity7(head)})};
  endfunction

  always_comb begin
    msg     = {c_q, 1'b0, flags_q};
    msg_bit = msg[idx];
    fb      = crc_q[2] ^ msg_bit;
    crc_nxt = {crc_q[1], crc_q[0] ^ fb, fb};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      c_q       <= 32'd0;
      flags_q   <= 4'd0;
      crc_q     <= 3'd0;
      idx       <= 6'd0;
      hold_cnt  <= '0;
      is_err    <= 1'b0;
      in_ready  <= 1'b0;
      aluin     <= 55'd0;
      dataready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            if (err_flags != 3'd0) begin
              is_err    <= 1'b1;
              aluin     <= err_frame(err_flags);
              dataready <= 1'b1;
              state     <= EMIT;
            end else begin
              is_err  <= 1'b0;
              c_q     <= c;
              flags_q <= flags;
              crc_q   <= 3'd0;
              idx     <= 6'd36;
              state   <= CRC;
            end
          end else begin
            in_ready <= 1'b1;
          end
        end
        // Last shift feeds the frame directly so EMIT lands one cycle after index 0.
        CRC: begin
          crc_q <= crc_nxt;
          if (idx == 6'd0) begin
            aluin     <= data_frame(c_q, flags_q, crc_nxt);
            dataready <= 1'b1;
            state     <= EMIT;
          end else begin
            idx <= idx - 6'd1;
          end
        end
        // Counter is preloaded one short so in_ready is already high HOLD_x cycles after EMIT.
        EMIT: begin
          dataready <= 1'b0;
          hold_cnt  <= is_err ? CNT_W'(HOLD_ERR - 1) : CNT_W'(HOLD_DATA - 1);
          state     <= HOLD;
        end
        HOLD: begin
          if (hold_cnt <= CNT_W'(1)) begin
            hold_cnt <= '0;
            in_ready <= 1'b1;
            state    <= IDLE;
          end else begin
            hold_cnt <= hold_cnt - CNT_W'(1);
          end
        end
        default: begin
          dataready <= 1'b0;
          in_ready  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mtm_alu_packer.md
# mtm_alu_packer

Output-side frame builder of the ALU. It accepts one ALU result (32-bit C plus 4 flags) or an error report per transaction and computes the 3-bit CRC bit-serially. It assembles either a 55-bit data frame or an 11-bit error frame and presents it to `mtm_Alu_serializer` on `aluin`/`dataready`. It paces the serializer: the next frame is not issued until the previous one has been fully shifted out.

## Interface
- `HOLD_DATA`, default 60: cycles in HOLD after a data frame; must be ≥ 58.
- `HOLD_ERR`, default 16: cycles in HOLD after an error frame; must be ≥ 14.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `in_valid` in 1: result/error present.
- `in_ready` out 1: block can accept; high only in IDLE.
- `c` in 32: ALU result.
- `flags` in 4: {carry, overflow, zero, negative}.
- `err_flags` in 3: {ERR_DATA, ERR_CRC, ERR_OP}; any bit set selects an error frame.
- `aluin` out 55: frame to the serializer.
- `dataready` out 1: one-cycle pulse; `aluin` is valid from this cycle on.

## Operation
- Packet format, 11 bits, MSB first: start `0`, type bit (`0` = data, `1` = ctl), 8-bit payload, stop `1`.
- Data frame (`err_flags == 0`):
  - `aluin[54:11]` = four data packets carrying C[31:24], C[23:16], C[15:8], C[7:0].
  - `aluin[10:0]` = ctl packet with payload {0, flags[3:0], crc[2:0]}.
  - `aluin[8]` = 0.
- Error frame (`err_flags != 0`):
  - `aluin[54:11]` = 0.
  - `aluin[10:0]` = ctl packet with payload {1, err_flags, err_flags, p}.
  - p = XOR of the first 7 payload bits, giving even parity over all 8. `aluin[8]` = 1.
- CRC: polynomial x^3+x+1, init 000, computed over the 37-bit message {c[31:0], 1'b0, flags[3:0]}, MSB first.
  - Per bit d: fb = crc[2]^d; crc <= {crc[1], crc[0]^fb, fb}.
- Accept: `in_valid & in_ready` at a rising edge. `c`, `flags` and `err_flags` are captured into internal registers; inputs are ignored at all other times.
- FSM:
  - IDLE: `in_ready` = 1. On accept, go to CRC if `err_flags == 0`, else to EMIT.
  - CRC: shift one message bit per cycle, 37 cycles via a 6-bit index 36..0. At index 0, go to EMIT.
  - EMIT: `aluin` loaded with the frame and `dataready` = 1 for this single cycle. Load the HOLD counter with HOLD_DATA or HOLD_ERR, then go to HOLD.
  - HOLD: decrement the counter; at 1, go to IDLE. `aluin` keeps its value.
- Error takes priority over the data path when `err_flags` is nonzero; `c` and `flags` are then ignored.
- `aluin` holds its last frame until the next EMIT.

## Timing
- Reset values: `aluin` = 0, `dataready` = 0, `in_ready` = 0 in the reset cycle and 1 in the first cycle after `rst` is released (IDLE). CRC = 000, counters = 0.
- `rst` asserted mid-CRC, mid-EMIT or mid-HOLD:
  - Next edge forces IDLE and the reset values.
  - Any pulse in flight is cancelled, and no partial frame is emitted.
- Latency, counted from the accept edge A:
  - Data frame: 37 CRC cycles, `dataready` high in the 38th cycle after A.
  - Error frame: `dataready` high in the 1st cycle after A.
- `in_ready` returns high exactly HOLD_x cycles after the EMIT cycle.
  - Accept-to-accept minimum: 38+HOLD_DATA cycles for data, 1+HOLD_ERR for error.
- `in_valid` held high continuously: exactly one accept per IDLE visit; no double capture.
- `in_valid` is allowed to change while `in_ready` is low; it has no effect then.

## Test plan
- Reset, then idle: `rst` 3 cycles → `aluin` = 0, `dataready` = 0, `in_ready` = 1 the cycle after release, and no pulse for 200 cycles.
- c = 0, flags = 0 →
  - one `dataready` pulse 38 cycles after accept;
  - `aluin` = {0x001, 0x001, 0x001, 0x001, 0x201} (11-bit groups, MSB group first).
- c = 1, flags = 0 →
  - CRC = 010;
  - `aluin` = {0x001, 0x001, 0x001, 0x003, 0x205}.
- err_flags = 3'b001, c = 0xFFFFFFFF →
  - pulse 1 cycle after accept;
  - `aluin[54:11]` = 0, `aluin[10:0]` = 0x327, `aluin[8]` = 1;
  - `in_ready` low for HOLD_ERR cycles.
- Back-to-back with `in_valid` held high, cascaded into `mtm_Alu_serializer`:
  - the serial output shows two complete, non-overlapping 55-bit frames;
  - the second accept occurs exactly 38+HOLD_DATA cycles after the first.
- `rst` pulsed at CRC index 10 → no `dataready`, `aluin` = 0; a new transaction after release produces a correct frame.
